// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: opcodes, alu_op classes, ALU operation codes,
// branch funct3 encodings and the control-strobe bundle.
package rv32i_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_R      = 2'b10,
    ALUOP_I      = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic    reg_write;
    logic    alu_src;
    logic    mem_write;
    logic    mem_read;
    logic    mem_to_reg;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  // Shared R/I-type funct3 table; alt selects SUB/SRA where the caller allows it.
  function automatic alu_ctrl_e arith_ctrl(input logic [2:0] funct3, input logic alt_add,
                                           input logic alt_shift);
    case (funct3)
      3'b000:  return alt_add ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt_shift ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_alu_core.sv
// Purely combinational 32-bit RV32I ALU datapath.
// Barrel shifter for SLL/SRL/SRA is built only when ALU_SHIFT_EN is defined.
module rv32i_alu_core
  import rv32i_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_ctrl_e   ctrl_i,
  output logic [31:0] result_o
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_ADD:  result_o = sum;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SUB:  result_o = diff;
      ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'd0, a_i < b_i};
`ifdef ALU_SHIFT_EN
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
`endif
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_decode_alu.sv
// RV32I decode-and-execute slice: combinational controller and ALU-control decode,
// registered result/zero/branch stage. Optional shifter via ALU_SHIFT_EN.
module rv32i_decode_alu
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_write,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        branch,
  output logic [1:0]  alu_op,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        branch_taken,
  output logic        valid_out
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  ctrl_t       ctrl;
  alu_ctrl_e   alu_ctrl_sel;
  logic [31:0] operand_b;
  logic [31:0] alu_result_d, alu_result_q;
  logic        zero_d, zero_q;
  logic        branch_taken_d, branch_taken_q;
  logic        valid_q;
  logic        branch_cond;
  logic        unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7_b5         = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    ctrl = '{default: '0, alu_op: ALUOP_ADD};
    case (opcode)
      OPC_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_R;
      end
      OPC_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_I;
      end
      OPC_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_BRANCH;
      end
      default: ;
    endcase
  end

  // Immediate ALU ops honour bit 30 only for shifts: addi with imm[10] set stays ADD.
  always_comb begin
    alu_ctrl_sel = ALU_ADD;
    case (ctrl.alu_op)
      ALUOP_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_ctrl_sel = ALU_SUB;
          3'b100, 3'b101: alu_ctrl_sel = ALU_SLT;
          3'b110, 3'b111: alu_ctrl_sel = ALU_SLTU;
          default:        alu_ctrl_sel = ALU_ADD;
        endcase
      end
      ALUOP_R: alu_ctrl_sel = arith_ctrl(funct3, funct7_b5, funct7_b5);
      ALUOP_I: alu_ctrl_sel = arith_ctrl(funct3, 1'b0, funct7_b5);
      default: alu_ctrl_sel = ALU_ADD;
    endcase
  end

  assign operand_b = ctrl.alu_src ? imm : rs2_data;

  rv32i_alu_core u_alu_core (
    .a_i      (rs1_data),
    .b_i      (operand_b),
    .ctrl_i   (alu_ctrl_sel),
    .result_o (alu_result_d)
  );

  assign zero_d = (alu_result_d == '0);

  always_comb begin
    branch_cond = 1'b0;
    case (funct3)
      F3_BEQ:           branch_cond = zero_d;
      F3_BNE:           branch_cond = !zero_d;
      F3_BLT, F3_BLTU:  branch_cond = alu_result_d[0];
      F3_BGE, F3_BGEU:  branch_cond = !alu_result_d[0];
      default:          branch_cond = 1'b0;
    endcase
  end

  assign branch_taken_d = ctrl.branch & branch_cond;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_result_q   <= '0;
      zero_q         <= 1'b0;
      branch_taken_q <= 1'b0;
      valid_q        <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        alu_result_q   <= alu_result_d;
        zero_q         <= zero_d;
        branch_taken_q <= branch_taken_d;
      end
    end
  end

  assign reg_write    = ctrl.reg_write;
  assign alu_src      = ctrl.alu_src;
  assign mem_write    = ctrl.mem_write;
  assign mem_read     = ctrl.mem_read;
  assign mem_to_reg   = ctrl.mem_to_reg;
  assign branch       = ctrl.branch;
  assign alu_op       = ctrl.alu_op;
  assign alu_ctrl     = alu_ctrl_sel;
  assign alu_result   = alu_result_q;
  assign zero         = zero_q;
  assign branch_taken = branch_taken_q;
  assign valid_out    = valid_q;

endmodule

// File: tb/tb_rv32i_decode_alu.sv
// Self-checking bench for rv32i_decode_alu: directed cases plus randomized
// instructions checked against an instruction-level reference model.
module tb_rv32i_decode_alu;

`ifdef ALU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, valid_in;
  logic [31:0] instr, rs1_data, rs2_data, imm;
  logic        reg_write, alu_src, mem_write, mem_read, mem_to_reg, branch;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero, branch_taken, valid_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] m_result;
  logic        m_zero, m_taken, m_valid;

  always #5 clk = ~clk;

  rv32i_decode_alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .instr        (instr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .imm          (imm),
    .reg_write    (reg_write),
    .alu_src      (alu_src),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_to_reg   (mem_to_reg),
    .branch       (branch),
    .alu_op       (alu_op),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .zero         (zero),
    .branch_taken (branch_taken),
    .valid_out    (valid_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // {reg_write, alu_src, mem_write, mem_read, mem_to_reg, branch, alu_op[1:0]}
  function automatic logic [7:0] ref_ctrl(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return 8'b1000_0010;
      7'b0010011: return 8'b1100_0011;
      7'b0000011: return 8'b1101_1000;
      7'b0100011: return 8'b0110_0000;
      7'b1100011: return 8'b0000_0101;
      default:    return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [3:0] ref_aluctl(input logic [31:0] ins);
    logic [2:0] f3;
    logic       alt;
    f3  = ins[14:12];
    alt = ins[30];
    if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011) begin
      case (f3)
        3'd0: return (alt && ins[6:0] == 7'b0110011) ? 4'd6 : 4'd2;
        3'd1: return 4'd4;
        3'd2: return 4'd8;
        3'd3: return 4'd9;
        3'd4: return 4'd3;
        3'd5: return alt ? 4'd7 : 4'd5;
        3'd6: return 4'd1;
        default: return 4'd0;
      endcase
    end else if (ins[6:0] == 7'b1100011) begin
      if (f3 <= 3'd1) return 4'd6;
      if (f3 == 3'd4 || f3 == 3'd5) return 4'd8;
      if (f3 >= 3'd6) return 4'd9;
      return 4'd2;
    end
    return 4'd2;
  endfunction

  function automatic bit lt_s(input logic [31:0] a, input logic [31:0] b);
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  // Instruction-level semantics; b is the already-selected second operand.
  function automatic logic [31:0] ref_result(input logic [31:0] ins, input logic [31:0] a,
                                             input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    bit          is_r;
    sh   = b[4:0];
    is_r = (ins[6:0] == 7'b0110011);
    if (is_r || ins[6:0] == 7'b0010011) begin
      case (ins[14:12])
        3'd0: return (is_r && ins[30]) ? a - b : a + b;
        3'd1: return SHIFT_EN ? a << sh : 32'd0;
        3'd2: return {31'd0, lt_s(a, b)};
        3'd3: return {31'd0, a < b};
        3'd4: return a ^ b;
        3'd5: begin
          if (!SHIFT_EN) return 32'd0;
          fill = (ins[30] && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
          return (a >> sh) | fill;
        end
        3'd6: return a | b;
        default: return a & b;
      endcase
    end else if (ins[6:0] == 7'b1100011) begin
      case (ins[14:12])
        3'd0, 3'd1: return a - b;
        3'd4, 3'd5: return {31'd0, lt_s(a, b)};
        3'd6, 3'd7: return {31'd0, a < b};
        default:    return a + b;
      endcase
    end
    return a + b;
  endfunction

  function automatic bit ref_taken(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b);
    if (ins[6:0] != 7'b1100011) return 1'b0;
    case (ins[14:12])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return lt_s(a, b);
      3'd5: return !lt_s(a, b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input bit v, input bit r, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b2, input logic [31:0] im);
    logic [7:0]  c;
    logic [31:0] b_eff;
    @(negedge clk);
    rst_n = r; valid_in = v; instr = ins; rs1_data = a; rs2_data = b2; imm = im;
    #1;
    c = ref_ctrl(ins);
    check("strobes", {24'd0, reg_write, alu_src, mem_write, mem_read, mem_to_reg, branch, alu_op},
          {24'd0, c});
    check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ref_aluctl(ins)});
    b_eff = c[6] ? im : b2;
    @(posedge clk);
    if (!r) begin
      m_result = 32'd0; m_zero = 1'b0; m_taken = 1'b0; m_valid = 1'b0;
    end else begin
      m_valid = v;
      if (v) begin
        m_result = ref_result(ins, a, b_eff);
        m_zero   = (m_result == 32'd0);
        m_taken  = ref_taken(ins, a, b_eff);
      end
    end
    #1;
    check("alu_result", alu_result, m_result);
    check("zero", {31'd0, zero}, {31'd0, m_zero});
    check("branch_taken", {31'd0, branch_taken}, {31'd0, m_taken});
    check("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
  endtask

  localparam logic [6:0] OPCS [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                      7'b0100011, 7'b1100011, 7'b0110111};

  initial begin
    logic [31:0] ins, a, b, im;
    rst_n = 1'b0; valid_in = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0; imm = '0;

    step(0, 0, 32'h0000_0013, 0, 0, 0);
    check("reset_result", alu_result, 32'd0);
    check("reset_valid", {31'd0, valid_out}, 32'd0);

    step(1, 1, 32'h4020_8033, 32'd5, 32'd7, 32'd0);
    check("sub_res", alu_result, 32'hFFFF_FFFE);
    check("sub_zero", {31'd0, zero}, 32'd0);

    step(1, 1, 32'h4000_0093, 32'd1, 32'd0, 32'h4000_0000);
    check("addi_bit30", alu_result, 32'h4000_0001);

    step(1, 1, 32'h0080_A083, 32'h100, 32'd0, 32'd8);
    check("lw_addr", alu_result, 32'h108);
    step(1, 1, 32'h0020_A423, 32'h100, 32'd9, 32'd4);
    check("sw_addr", alu_result, 32'h104);

    step(1, 1, 32'h0020_8063, 32'd3, 32'd3, 32'd0);
    check("beq_taken", {31'd0, branch_taken}, 32'd1);
    check("beq_zero", {31'd0, zero}, 32'd1);
    step(1, 1, 32'h0020_9063, 32'd3, 32'd3, 32'd0);
    check("bne_taken", {31'd0, branch_taken}, 32'd0);
    step(1, 1, 32'h0020_C063, 32'hFFFF_FFFF, 32'd1, 32'd0);
    check("blt_taken", {31'd0, branch_taken}, 32'd1);
    step(1, 1, 32'h0020_E063, 32'hFFFF_FFFF, 32'd1, 32'd0);
    check("bltu_taken", {31'd0, branch_taken}, 32'd0);

    step(1, 1, 32'h4040_D093, 32'h8000_0000, 32'd0, 32'h0000_0404);
    check("srai", alu_result, SHIFT_EN ? 32'hF800_0000 : 32'd0);
    check("srai_zero", {31'd0, zero}, SHIFT_EN ? 32'd0 : 32'd1);
    step(1, 1, 32'h0040_D093, 32'h8000_0000, 32'd0, 32'd4);
    check("srli", alu_result, SHIFT_EN ? 32'h0800_0000 : 32'd0);

    step(1, 0, 32'h0020_8033, 32'd4, 32'd4, 32'd0);
    check("rst_pri_result", alu_result, 32'd0);
    check("rst_pri_valid", {31'd0, valid_out}, 32'd0);
    step(1, 1, 32'h0020_0093, 32'd1, 32'd0, 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h0020_8033, $urandom, $urandom, $urandom);
      check("hold_result", alu_result, 32'd3);
    end

    step(1, 1, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3);
    check("unknown_strobes", {24'd0, reg_write, alu_src, mem_write, mem_read, mem_to_reg,
          branch, alu_op}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      ins = {$urandom, 7'd0};
      ins[6:0] = OPCS[$urandom_range(0, 5)];
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      im = ($urandom_range(0, 1) == 0) ? {{20{ins[31]}}, ins[31:20]} : $urandom;
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 15) != 0), ins, a, b, im);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_alu.md
# rv32i_decode_alu

Decode-and-execute slice of the single-cycle RV32I core. Combines the opcode controller, the ALU-control decoder and the 32-bit ALU. It sits between the register file / immediate generator and the data-memory stage. Control strobes are combinational from the instruction; the ALU result, zero flag and branch decision are registered.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- valid_in  in  1  instr/operands valid this cycle
- instr  in  32  current instruction word
- rs1_data  in  32  ALU operand A
- rs2_data  in  32  register operand B
- imm  in  32  sign-extended immediate
- reg_write, alu_src, mem_write, mem_read, mem_to_reg, branch  out  1 each  combinational control strobes
- alu_op  out  2  combinational class code
- alu_ctrl  out  4  combinational ALU operation select
- alu_result  out  32  registered ALU result
- zero  out  1  registered, alu_result == 0
- branch_taken  out  1  registered branch decision
- valid_out  out  1  registered copy of valid_in

## Operation
- Controller on instr[6:0]; strobes not listed are 0:
  - 0110011 R: reg_write, alu_op=10
  - 0010011 I-ALU: reg_write, alu_src, alu_op=11
  - 0000011 load: reg_write, alu_src, mem_read, mem_to_reg, alu_op=00
  - 0100011 store: alu_src, mem_write, alu_op=00
  - 1100011 branch: branch, alu_op=01
  - any other opcode: all strobes 0, alu_op=00
- ALU control codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001. Unused codes give result 0.
- alu_op 00 selects ADD.
- alu_op 01 selects by funct3:
  - 000/001 → SUB
  - 100/101 → SLT
  - 110/111 → SLTU
  - 010/011 → ADD
- alu_op 10 selects by funct3:
  - 000 → ADD, or SUB if funct7[5]
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
  - 101 → SRL, or SRA if funct7[5]
  - 110 OR, 111 AND
- alu_op 11 uses the same table as alu_op 10, but funct7[5] is honoured only for funct3=101. addi with imm bit 30 set is ADD.
- Operand B = alu_src ? imm : rs2_data.
- Arithmetic:
  - ADD/SUB are mod 2^32; overflow is ignored.
  - Shift amount = B[4:0].
  - SRA is sign-filling.
  - SLT is a signed compare and SLTU unsigned; both return 32'd0 or 32'd1.
- Branch condition, by funct3:
  - 000 → zero
  - 001 → !zero
  - 100/110 → result[0]
  - 101/111 → !result[0]
  - 010/011 → 0
  - branch_taken = branch & condition.

## Timing
- Control strobes and alu_ctrl: zero-latency combinational. They follow instr regardless of valid_in or reset.
- alu_result, zero, branch_taken: captured on the rising edge when valid_in=1; they hold when valid_in=0. Latency is 1 cycle.
- valid_out <= valid_in every edge.
- Reset (rst_n=0 at edge) forces alu_result=0, zero=0, branch_taken=0, valid_out=0.
  - Reset has priority over valid_in.
  - An operation in flight during reset is dropped.
- Back-to-back valid_in=1 yields one result per cycle; there is no backpressure.

## Configuration
- ALU_SHIFT_EN defined: the 32-bit barrel shifter for SLL/SRL/SRA is built.
- ALU_SHIFT_EN undefined: no shifter is built. Shift codes produce result 0, so zero=1. The decode tables are unchanged.

## Structure
- Shared package `rv32i_pkg`:
  - opcode constants
  - alu_op class encodings
  - 4-bit ALU operation codes
  - funct3 branch encodings
- One sub-module, `rv32i_alu_core`: the purely combinational 32-bit datapath (operands + code → result).
- Controller and ALU-control decode live in the top as combinational logic. The result/flag register stage is also in the top.

## Test plan
- R-type sub, x1=5, x2=7 (instr 0x40208033): alu_ctrl=0110, reg_write=1; after 1 clk alu_result=0xFFFFFFFE, zero=0.
- addi, imm=0x40000000 with rs1=1: alu_op=11, ADD selected (not SUB), result 0x40000001.
- Load lw, rs1=0x100, imm=8: mem_read=1, mem_to_reg=1, alu_src=1; result 0x108. Store: mem_write=1, reg_write=0.
- Branch, rs1=rs2=3:
  - beq → branch_taken=1, zero=1.
  - bne → branch_taken=0.
  - blt with rs1=-1, rs2=1 → taken.
  - bltu with the same operands → not taken.
- srai, rs1=0x80000000, shamt 4: 0xF8000000. srli: 0x08000000. With ALU_SHIFT_EN undefined: 0 and zero=1.
- rst_n=0 with valid_in=1 → next edge all registered outputs 0. valid_in=0 for 3 cycles → alu_result holds. Unknown opcode 0x7F → all strobes 0.
